pe_array_seq_ctrl: RTL

- Sequences the control sideband of the unary-temporal systolic PE array.
- Drives en_i/clr_i, en_w/clr_w, en_o/clr_o and mac_done into the border PEs; the PE chain propagates them one hop per cycle.
- Per weight tile: clears all registers, loads the weights, then runs a configured number of unary MAC windows, each with a configured unary cycle count for early termination.
- Sits between the top-level tile scheduler (start/done handshake) and the array edge.

---
 rtl/pe_array_seq_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pe_array_seq_ctrl.sv
// Control sideband sequencer for the unary-temporal systolic PE array: per tile it
// clears, loads weights, then runs num_mac unary MAC windows of C cycles each.
module pe_array_seq_ctrl #(
    parameter int IWIDTH = 8,
    parameter int NWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NWIDTH-1:0] cfg_num_mac,
    input  logic [IWIDTH-1:0] cfg_cycles,
    output logic              busy,
    output logic              done,
    output logic              en_i,
    output logic              clr_i,
    output logic              en_w,
    output logic              clr_w,
    output logic              en_o,
    output logic              clr_o,
    output logic              mac_done
);

    typedef enum logic [2:0] {IDLE, CLR, WLOAD, INIT, RUN, DONE} state_t;

    localparam logic [IWIDTH-1:0] FULL_WINDOW = {1'b1, {(IWIDTH-1){1'b0}}};

    // Zero means "full window"; anything longer than a full window is clipped to it.
    function automatic logic [IWIDTH-1:0] sat_cycles(input logic [IWIDTH-1:0] cfg);
        if (cfg == '0 || cfg > FULL_WINDOW)
            return FULL_WINDOW;
        return cfg;
    endfunction

    state_t            state, state_d;
    logic [NWIDTH-1:0] num_mac, num_mac_d;
    logic [IWIDTH-1:0] cycles, cycles_d;
    logic [IWIDTH-1:0] cyc_cnt, cyc_cnt_d;
    logic [NWIDTH-1:0] mac_cnt, mac_cnt_d;
    logic [8:0]        outs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            num_mac <= '0;
            cycles  <= '0;
            cyc_cnt <= '0;
            mac_cnt <= '0;
        end else begin
            state   <= state_d;
            num_mac <= num_mac_d;
            cycles  <= cycles_d;
            cyc_cnt <= cyc_cnt_d;
            mac_cnt <= mac_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        num_mac_d = num_mac;
        cycles_d  = cycles;
        cyc_cnt_d = cyc_cnt;
        mac_cnt_d = mac_cnt;
        if (abort) begin
            state_d   = IDLE;
            num_mac_d = '0;
            cycles_d  = '0;
            cyc_cnt_d = '0;
            mac_cnt_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_d   = CLR;
                        num_mac_d = cfg_num_mac;
                        cycles_d  = sat_cycles(cfg_cycles);
                    end
                end
                CLR: state_d = WLOAD;
                WLOAD: begin
                    if (num_mac == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = INIT;
                        cyc_cnt_d = cycles - 1'b1;
                        mac_cnt_d = '0;
                    end
                end
                INIT: state_d = RUN;
                RUN: begin
                    if (cyc_cnt == '0) begin
                        mac_cnt_d = mac_cnt + 1'b1;
                        if (mac_cnt_d == num_mac) begin
                            state_d = DONE;
                        end else begin
                            state_d   = INIT;
                            cyc_cnt_d = cycles - 1'b1;
                        end
                    end else begin
                        cyc_cnt_d = cyc_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state_d   = IDLE;
                    num_mac_d = '0;
                    cycles_d  = '0;
                    mac_cnt_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        outs_d = '0;
        case (state_d)
            CLR:     outs_d = 9'b1_0_0_1_0_1_0_1_0;
            WLOAD:   outs_d = 9'b1_0_0_0_1_0_0_0_0;
            INIT:    outs_d = 9'b1_0_1_0_0_0_0_0_0;
            RUN:     outs_d = {8'b1_0_0_0_0_0_1_0, cyc_cnt_d == '0};
            DONE:    outs_d = 9'b1_1_0_0_0_0_0_0_0;
            default: outs_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done} <= '0;
        else
            {busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done} <= outs_d;
    end

endmodule
